// File: rtl/linear_interp_if.sv
// Sample-side handshake plus modulator-side output bundle for linear_interp.
// The master side drives samples and the underrun clear. The slave side is the interpolator.
interface linear_interp_if #(
  parameter int MSB = 16
);
  logic signed [MSB-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic        [MSB-1:0] dac_out;
  logic                  sample_tick;
  logic                  underrun;
  logic                  underrun_clr;

  modport master (
    output s_data, s_valid, underrun_clr,
    input  s_ready, dac_out, sample_tick, underrun
  );

  modport slave (
    input  s_data, s_valid, underrun_clr,
    output s_ready, dac_out, sample_tick, underrun
  );
endinterface

// File: rtl/linear_interp.sv
// Upsampling linear interpolator: ramps between successive signed PCM samples over
// 2**OSR_LOG2 clocks and emits one offset-binary word per clock for the modulator.
module linear_interp #(
  parameter int MSB      = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  linear_interp_if.slave  bus
);
  localparam int AW = MSB + OSR_LOG2 + 1;

  logic        [OSR_LOG2-1:0] r_phase;
  logic                       r_hold_v;
  logic signed [MSB-1:0]      r_hold;
  logic signed [MSB-1:0]      r_cur;
  logic signed [MSB:0]        r_delta;
  logic signed [AW-1:0]       r_acc;
  logic                       r_s_ready;
  logic                       r_tick;
  logic                       r_underrun;

  logic                       w_wrap;
  logic                       w_xfer;
  logic                       w_hold_v_nxt;
  logic signed [MSB-1:0]      w_hold_nxt;
  logic signed [MSB-1:0]      w_cur_nxt;
  logic signed [MSB:0]        w_delta_nxt;
  logic signed [AW-1:0]       w_acc_nxt;
  logic                       w_underrun_nxt;
  logic signed [MSB-1:0]      w_level;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    w_wrap         = (r_phase == '1);
    w_xfer         = bus.s_valid & r_s_ready;
    w_hold_v_nxt   = r_hold_v;
    w_hold_nxt     = r_hold;
    w_cur_nxt      = r_cur;
    w_delta_nxt    = r_delta;
    w_acc_nxt      = r_acc + {{OSR_LOG2{r_delta[MSB]}}, r_delta};
    w_underrun_nxt = r_underrun & ~bus.underrun_clr;

    if (w_wrap) begin
      // Restart the ramp exactly on the outgoing sample, scaled by N.
      w_acc_nxt = {r_cur[MSB-1], r_cur, {OSR_LOG2{1'b0}}};
      if (r_hold_v) begin
        w_delta_nxt  = {r_hold[MSB-1], r_hold} - {r_cur[MSB-1], r_cur};
        w_cur_nxt    = r_hold;
        w_hold_v_nxt = 1'b0;
      end else begin
        w_delta_nxt    = '0;
        w_underrun_nxt = 1'b1;
      end
    end

    // A transfer cannot collide with a consuming wrap: s_ready is low whenever hold is full.
    if (w_xfer) begin
      w_hold_nxt   = bus.s_data;
      w_hold_v_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_phase    <= '0;
      r_hold_v   <= 1'b0;
      r_hold     <= '0;
      r_cur      <= '0;
      r_delta    <= '0;
      r_acc      <= '0;
      r_s_ready  <= 1'b1;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_phase    <= r_phase + 1'b1;
      r_hold_v   <= w_hold_v_nxt;
      r_hold     <= w_hold_nxt;
      r_cur      <= w_cur_nxt;
      r_delta    <= w_delta_nxt;
      r_acc      <= w_acc_nxt;
      r_s_ready  <= ~w_hold_v_nxt;
      r_tick     <= w_wrap;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Arithmetic shift floors toward -inf; flipping the sign bit converts to offset binary.
  assign w_level         = MSB'(r_acc >>> OSR_LOG2);
  assign bus.dac_out     = {~w_level[MSB-1], w_level[MSB-2:0]};
  assign bus.s_ready     = r_s_ready;
  assign bus.sample_tick = r_tick;
  assign bus.underrun    = r_underrun;
endmodule

// File: tb/tb_linear_interp.sv
// Self-checking bench for linear_interp (MSB=16, OSR_LOG2=2): directed ramps plus random
// traffic compared every clock against an arithmetic model of the interpolated line.
module tb_linear_interp;
  localparam int MSB  = 16;
  localparam int K    = 2;
  localparam int N    = 1 << K;
  localparam int HALF = 1 << (MSB - 1);
  localparam int MASK = (1 << MSB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  linear_interp_if #(.MSB(MSB)) ifc ();

  linear_interp #(.MSB(MSB), .OSR_LOG2(K)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the line from m_old to m_new, sampled at step m_phase out of N.
  int m_phase, m_hold, m_old, m_new;
  bit m_hold_v, m_tick, m_under;
  int m_xfers, dut_xfers;

  logic [MSB-1:0] t1 [N+1] = '{16'h8000, 16'h8040, 16'h8080, 16'h80C0, 16'h8100};
  logic [MSB-1:0] t2 [N+1] = '{16'h8000, 16'h7FFF, 16'h7FFE, 16'h7FFD, 16'h7FFD};
  logic [MSB-1:0] t3 [N+1] = '{16'h0000, 16'h3FFF, 16'h7FFF, 16'hBFFF, 16'hFFFF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_dac(input int old_v, input int new_v, input int i);
    int num, q;
    num = old_v * N + i * (new_v - old_v);
    if (num >= 0) q = num / N;
    else          q = -((-num + N - 1) / N);
    return (q + HALF) & MASK;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_old = 0; m_new = 0;
    m_hold_v = 0; m_tick = 0; m_under = 0;
  endtask

  task automatic tick();
    bit wrap, xfer, clr, starve;
    int din;
    wrap   = (m_phase == N - 1);
    xfer   = ifc.s_valid && !m_hold_v;
    starve = wrap && !m_hold_v;
    clr    = ifc.underrun_clr;
    din    = int'(ifc.s_data);
    if (ifc.s_valid && ifc.s_ready) dut_xfers++;
    if (xfer) m_xfers++;
    @(posedge clk);
    #1;
    if (starve) m_under = 1;
    else if (clr) m_under = 0;
    if (wrap) begin
      m_old = m_new;
      if (m_hold_v) begin
        m_new    = m_hold;
        m_hold_v = 0;
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (xfer) begin
      m_hold   = din;
      m_hold_v = 1;
    end
    m_tick = wrap;
    check("dac_out", ifc.dac_out, exp_dac(m_old, m_new, m_phase));
    check("s_ready", ifc.s_ready, !m_hold_v);
    check("sample_tick", ifc.sample_tick, m_tick);
    check("underrun", ifc.underrun, m_under);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.s_valid = 1'b0;
    ifc.underrun_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int v);
    bit done;
    done = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = v[MSB-1:0];
    for (int k = 0; k < 4 * N && !done; k++) begin
      done = !m_hold_v;
      tick();
    end
    ifc.s_valid = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $error("FAIL push_timeout observed=0 expected=1");
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int k = 0; k < 2 * N && !seen; k++) begin
      tick();
      seen = m_tick;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $error("FAIL wrap_timeout observed=0 expected=1");
    end
  endtask

  task automatic ramp_check(input string tag, input logic [MSB-1:0] e [N+1]);
    check({tag, "_0"}, ifc.dac_out, e[0]);
    check({tag, "_tick"}, ifc.sample_tick, 1);
    for (int s = 1; s <= N; s++) begin
      tick();
      check($sformatf("%s_%0d", tag, s), ifc.dac_out, e[s]);
    end
  endtask

  initial begin
    int cnt;
    int x0, m0;
    ifc.s_valid = 1'b0;
    ifc.s_data = '0;
    ifc.underrun_clr = 1'b0;
    m_xfers = 0;
    dut_xfers = 0;

    // Reset state and first ramp
    do_reset();
    check("rst_dac", ifc.dac_out, 16'h8000);
    check("rst_ready", ifc.s_ready, 1);
    check("rst_underrun", ifc.underrun, 0);
    check("rst_tick", ifc.sample_tick, 0);
    push(16'h0100);
    wait_tick();
    ramp_check("ramp_pos", t1);

    // Negative step floors toward -inf
    do_reset();
    push(-3);
    wait_tick();
    ramp_check("ramp_neg", t2);

    // Full-scale swing
    push(-32768);
    wait_tick();
    push(32767);
    wait_tick();
    ramp_check("ramp_full", t3);

    // Underrun: set, clear, and set-over-clear priority
    push(16'h0400);
    ifc.underrun_clr = 1'b1;
    tick();
    ifc.underrun_clr = 1'b0;
    check("ur_cleared_pending", ifc.underrun, 0);
    wait_tick();
    wait_tick();
    check("ur_hold_dac", ifc.dac_out, 16'h8400);
    check("ur_set", ifc.underrun, 1);
    ifc.underrun_clr = 1'b1;
    tick();
    ifc.underrun_clr = 1'b0;
    check("ur_clr", ifc.underrun, 0);
    ifc.underrun_clr = 1'b1;
    wait_tick();
    ifc.underrun_clr = 1'b0;
    check("ur_set_priority", ifc.underrun, 1);
    check("ur_flat_dac", ifc.dac_out, 16'h8400);

    // Backpressure: continuous valid with an incrementing counter
    cnt = int'($urandom_range(0, 2000)) - 1000;
    x0 = dut_xfers;
    m0 = m_xfers;
    ifc.s_valid = 1'b1;
    for (int k = 0; k < 8 * N; k++) begin
      bit acc;
      ifc.s_data = cnt[MSB-1:0];
      acc = ifc.s_ready;
      tick();
      if (acc) cnt = cnt + 257;
    end
    ifc.s_valid = 1'b0;
    check("bp_xfer_count", dut_xfers - x0, m_xfers - m0);

    // Random traffic with occasional gaps and clears
    for (int k = 0; k < 300; k++) begin
      ifc.s_valid      = ($urandom_range(0, 3) != 0);
      ifc.s_data       = MSB'($urandom);
      ifc.underrun_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    ifc.s_valid = 1'b0;
    ifc.underrun_clr = 1'b0;

    // Reset mid-ramp with a sample buffered at phase 2
    push(16'h1234);
    wait_tick();
    push(-16'sd2000);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dac", ifc.dac_out, 16'h8000);
    check("async_rst_ready", ifc.s_ready, 1);
    check("async_rst_underrun", ifc.underrun, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N - 1; k++) tick();
    check("restart_no_tick", ifc.sample_tick, 0);
    tick();
    check("restart_tick", ifc.sample_tick, 1);
    check("restart_dac", ifc.dac_out, 16'h8000);
    check("restart_dropped", ifc.underrun, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
